max_pool_l1: RTL and testbench

Layer-1 max-pooling engine: the stage directly downstream of the layer-0 convolution/ReLU engine. Once layer 0 has filled its result bank (64×64, csel 3'b001), this block reads that bank through the shared result-memory port, takes the maximum of each non-overlapping 2×2 window with stride 2, and writes the 32×32 result to the layer-1 bank (csel 3'b011). It is started by the top controller with a one-cycle `start` pulse and reports completion with a one-cycle `done` pulse.

---
 rtl/max_pool_l1_pkg.sv | 22 ++
 rtl/max_pool_l1_cmp.sv | 47 ++++
 rtl/max_pool_l1.sv | 165 ++++++++++++++++
 tb/tb_max_pool_l1.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max_pool_l1_pkg.sv
// Shared definitions for the layer-1 max-pooling engine.
// Holds the result-memory bank selects, the default geometry and data widths,
// and the FSM state encoding used by max_pool_l1.
package max_pool_l1_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;
    localparam int IMG_W      = 64;

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/max_pool_l1_cmp.sv
// max_pool_cmp: registered running-maximum unit.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   clear        force the register to 0 (highest priority)
//   load         load din unconditionally (first pixel of a window)
//   update       replace the register with din only if din is strictly larger
//   din          candidate pixel
//   max_o        current maximum
module max_pool_cmp
    import max_pool_l1_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         update,
    input  logic [W-1:0] din,
    output logic [W-1:0] max_o
);

    logic [W-1:0] max_q, max_d;

    // Unsigned compare; on a tie the held value is kept.
    always_comb begin
        max_d = max_q;
        if (clear) begin
            max_d = '0;
        end else if (load) begin
            max_d = din;
        end else if (update && (din > max_q)) begin
            max_d = din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max_o = max_q;

endmodule

// File: rtl/max_pool_l1.sv
// max_pool_l1: 2x2 / stride-2 max pooling of the layer-0 result bank into the
// layer-1 bank over a shared single-port result memory.
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   start                 one-cycle request, accepted only when idle
//   busy, done            status; done pulses once after the last write
//   crd, caddr_rd         read strobe / address (bank csel=001)
//   cdata_rd              read data, valid the cycle after the read strobe
//   cwr, caddr_wr, cdata_wr  write strobe / address / data (bank csel=011)
//   csel                  bank select, 000 when the port is unused
// Every output is a decode of registered state, so an asserted reset clears
// all of them immediately and no partial write can escape.
module max_pool_l1
    import max_pool_l1_pkg::*;
#(
    parameter int DATA_WIDTH = max_pool_l1_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = max_pool_l1_pkg::ADDR_WIDTH,
    parameter int IMG_W      = max_pool_l1_pkg::IMG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  crd,
    output logic [ADDR_WIDTH-1:0] caddr_rd,
    input  logic [DATA_WIDTH-1:0] cdata_rd,
    output logic                  cwr,
    output logic [ADDR_WIDTH-1:0] caddr_wr,
    output logic [DATA_WIDTH-1:0] cdata_wr,
    output logic [2:0]            csel
);

    // Bits of one output coordinate (r or c); input coordinates need one more.
    localparam int HW = $clog2(IMG_W) - 1;

    state_e          state_q, state_d;
    logic [HW-1:0]   r_q, r_d;
    logic [HW-1:0]   c_q, c_d;
    logic [1:0]      k_q, k_d;

    logic                  cmp_load, cmp_update, cmp_clear;
    logic [DATA_WIDTH-1:0] max_val;
    logic                  last_win;
    logic [2*HW+1:0]       rd_addr;
    logic [2*HW-1:0]       wr_addr;

    assign last_win = (&r_q) && (&c_q);

    // Input address (2r+k[1])*IMG_W + 2c+k[0] is just bit concatenation
    // because IMG_W is a power of two.
    assign rd_addr = {r_q, k_q[1], c_q, k_q[0]};
    assign wr_addr = {r_q, c_q};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                k_d = '0;
                if (last_win) begin
                    state_d = ST_FIN;
                    r_d     = '0;
                    c_d     = '0;
                end else begin
                    state_d = ST_RD;
                    c_d     = c_q + HW'(1);
                    if (&c_q) begin
                        r_d = r_q + HW'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
        end
    end

    // Read data lags the strobe by a cycle: the k=0 pixel arrives during
    // RD k=1 (load), k=1..3 pixels during RD k=2, RD k=3 and CAP (update).
    assign cmp_load   = (state_q == ST_RD) && (k_q == 2'd1);
    assign cmp_update = ((state_q == ST_RD) && (k_q[1] == 1'b1)) || (state_q == ST_CAP);
    assign cmp_clear  = (state_q == ST_FIN);

    max_pool_cmp #(
        .W (DATA_WIDTH)
    ) u_cmp (
        .clk    (clk),
        .reset  (reset),
        .clear  (cmp_clear),
        .load   (cmp_load),
        .update (cmp_update),
        .din    (cdata_rd),
        .max_o  (max_val)
    );

    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        csel     = CSEL_IDLE;
        case (state_q)
            ST_RD: begin
                crd      = 1'b1;
                csel     = CSEL_L0;
                caddr_rd = ADDR_WIDTH'(rd_addr);
            end
            ST_CAP: begin
                csel = CSEL_L0;
            end
            ST_WR: begin
                cwr      = 1'b1;
                csel     = CSEL_L1;
                caddr_wr = ADDR_WIDTH'(wr_addr);
                cdata_wr = max_val;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_max_pool_l1.sv
module tb_max_pool_l1;
    import max_pool_l1_pkg::*;

    localparam int DW   = 20;
    localparam int AW   = 12;
    localparam int N    = 64;
    localparam int M    = N / 2;
    localparam int NWIN = M * M;
    localparam int RUN  = 6 * NWIN;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd = '0;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    always #5 clk = ~clk;

    max_pool_l1 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_W      (N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    // Layer-0 bank model: registered read, data valid the cycle after crd.
    logic [DW-1:0] mem [N*N];
    int wr_count = 0;

    always @(posedge clk) begin
        if (crd) cdata_rd <= mem[caddr_rd];
        if (cwr) wr_count <= wr_count + 1;
    end

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0][DW-1:0] px;   // TL, TR, BL, BR of window (0,0)
        logic [DW-1:0]      exp;
    } vec_t;
    vec_t tbl [6];

    // Reference: plain maximum of the four input pixels of output pixel (r,c).
    function automatic logic [DW-1:0] win_max(int r, int c);
        logic [DW-1:0] best;
        logic [DW-1:0] v;
        best = '0;
        for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
                v = mem[(2*r+dy)*N + 2*c + dx];
                if (v > best) best = v;
            end
        return best;
    endfunction

    function automatic logic [50:0] outs();
        return {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr};
    endfunction

    // Expected port state in cycle n of a run (n counted from the start edge).
    task automatic check_cycle(input int n, input string tag);
        logic          e_busy, e_done, e_crd, e_cwr;
        logic [2:0]    e_csel;
        logic [AW-1:0] e_ard, e_awr;
        logic [DW-1:0] e_dwr;
        logic [50:0]   exp_v, got_v;
        int w, p, r, c;
        e_busy = 0; e_done = 0; e_crd = 0; e_cwr = 0;
        e_csel = 3'b000; e_ard = '0; e_awr = '0; e_dwr = '0;
        if (n >= 1 && n <= RUN) begin
            w = (n - 1) / 6;
            p = (n - 1) % 6;
            r = w / M;
            c = w % M;
            e_busy = 1;
            if (p < 4) begin
                e_crd  = 1;
                e_csel = 3'b001;
                e_ard  = AW'((2*r + p/2) * N + 2*c + p%2);
            end else if (p == 4) begin
                e_csel = 3'b001;
            end else begin
                e_cwr  = 1;
                e_csel = 3'b011;
                e_awr  = AW'(w);
                e_dwr  = win_max(r, c);
            end
        end else if (n == RUN + 1) begin
            e_busy = 1;
            e_done = 1;
        end
        exp_v = {e_busy, e_done, e_crd, e_cwr, e_csel, e_ard, e_awr, e_dwr};
        got_v = outs();
        checks++;
        if (got_v !== exp_v || (crd && cwr)) begin
            failures++;
            $display("FAIL %s cycle=%0d got busy=%b done=%b crd=%b cwr=%b csel=%b ard=%0d awr=%0d dwr=%h required busy=%b done=%b crd=%b cwr=%b csel=%b ard=%0d awr=%0d dwr=%h",
                     tag, n, busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr,
                     e_busy, e_done, e_crd, e_cwr, e_csel, e_ard, e_awr, e_dwr);
        end
    endtask

    task automatic run_full(input bit repulse, input string tag);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int n = 1; n <= RUN + 2; n++) begin
            check_cycle(n, tag);
            start = repulse && (n == 3 || n == 3000);
            @(negedge clk);
        end
        start = 0;
        $display("run %s: checked %0d cycles, writes so far %0d", tag, RUN + 2, wr_count);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (outs() !== '0) begin
            failures++;
            $display("FAIL %s got outputs=%h required 0", tag, outs());
        end
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d, input int e);
        tbl[i].px[0] = DW'(a);
        tbl[i].px[1] = DW'(b);
        tbl[i].px[2] = DW'(c);
        tbl[i].px[3] = DW'(d);
        tbl[i].exp   = DW'(e);
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < N*N; a++) mem[a] = DW'(a);
    endtask

    initial begin
        int wr_before;
        logic [DW-1:0] got_d;

        set_vec(0, 900, 3, 2, 1, 900);
        set_vec(1, 3, 900, 2, 1, 900);
        set_vec(2, 3, 2, 900, 1, 900);
        set_vec(3, 3, 2, 1, 900, 900);
        set_vec(4, 0, 0, 0, 0, 0);
        set_vec(5, 'hFFFFE, 'h7FFFF, 5, 'hFFFFF, 'hFFFFF);

        for (int a = 0; a < N*N; a++) mem[a] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1;
        @(negedge clk);

        // Table: max position and tie/zero cases in window (0,0), first write only
        for (int i = 0; i < 6; i++) begin
            mem[0]   = tbl[i].px[0];
            mem[1]   = tbl[i].px[1];
            mem[N]   = tbl[i].px[2];
            mem[N+1] = tbl[i].px[3];
            @(negedge clk);
            start = 1;
            @(negedge clk);
            start = 0;
            for (int n = 1; n <= 5; n++) begin
                check_cycle(n, "vec_pre");
                @(negedge clk);
            end
            got_d = cdata_wr;
            checks++;
            if (!(cwr === 1'b1 && caddr_wr === '0 && got_d === tbl[i].exp)) begin
                failures++;
                $display("FAIL vec%0d got cwr=%b addr=%0d data=%0d required cwr=1 addr=0 data=%0d",
                         i, cwr, caddr_wr, got_d, tbl[i].exp);
            end
            $display("vec%0d: px=%0d,%0d,%0d,%0d wrote %0d", i, tbl[i].px[0], tbl[i].px[1],
                     tbl[i].px[2], tbl[i].px[3], got_d);
            reset = 0;
            @(negedge clk);
            reset = 1;
        end

        // Ramp image, full run
        fill_ramp();
        run_full(0, "ramp");

        // Ramp with start re-pulsed mid-run
        run_full(1, "repulse");

        // Reset mid-window (cycle 4), then a clean ramp run
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        for (int n = 1; n <= 4; n++) begin
            check_cycle(n, "pre_rst");
            if (n < 4) @(negedge clk);
        end
        wr_before = wr_count;
        reset = 0;
        #1;
        check_zero("rst_immediate");
        repeat (3) @(negedge clk);
        reset = 1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check_zero("rst_idle");
        end
        checks++;
        if (wr_count != wr_before) begin
            failures++;
            $display("FAIL no_partial_wr got writes=%0d required %0d", wr_count - wr_before, 0);
        end
        $display("reset mid-window: writes after reset=%0d", wr_count - wr_before);
        run_full(0, "ramp_after_rst");

        // All pixels with the top bit set
        for (int a = 0; a < N*N; a++) mem[a] = 20'h80000;
        run_full(0, "top_bit");

        // Random image
        for (int a = 0; a < N*N; a++) mem[a] = DW'($urandom & 32'h000F_FFFF);
        run_full(0, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
